// File: rtl/square_pkg.sv
// square_pkg: shared state encoding, result record and width helpers for the square extractor sequencer
package square_pkg;
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int OBUF_ENTRIES = 2;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] root;
    logic                 exact;
  } result_t;
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sq_result_fifo2.sv
// sq_result_fifo2: two-entry FIFO whose head register drives the output directly
module sq_result_fifo2 #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic [1:0]    occupancy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  logic [DW-1:0] tail;
  logic          pop;
  assign out_valid = occupancy != 2'd0;
  assign pop = out_valid && out_ready;
  // a write alongside a pop lands in the head only when the head is leaving and nothing is behind it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occupancy <= 2'd0;
      out_data <= '0;
      tail <= '0;
    end else begin
      out_data <= pop ? ((wr_en && occupancy == 2'd1) ? wr_data : tail)
                      : ((wr_en && occupancy == 2'd0) ? wr_data : out_data);
      tail <= (wr_en && occupancy == (pop ? 2'd2 : 2'd1)) ? wr_data : tail;
      occupancy <= occupancy + 2'(wr_en) - 2'(pop);
    end
endmodule

// File: rtl/square_extractor_seq_ctrl.sv
// square_extractor_seq_ctrl: feeds an external square extractor, waits out its latency and buffers root/exact results
module square_extractor_seq_ctrl
  import square_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = WIDTH,
  parameter int OBUF_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_radicand,
  output logic [2*WIDTH-1:0] sq_radicand,
  input  logic [WIDTH-1:0]   sq_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_root,
  output logic               out_exact,
  output logic               busy
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = cnt_bits(HOLD_CYCLES);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rad_q, dout_ext;
  logic [1:0]    occupancy;
  logic [WIDTH:0] head;
  logic          accept, capture, exact;
  // admission reserves the buffer slot; occupancy can only drop while holding
  assign in_ready = rst_n && state == ST_IDLE && int'(occupancy) < OBUF_DEPTH;
  assign accept = in_valid && in_ready;
  assign capture = state == ST_HOLD && cnt == '0;
  assign dout_ext = {{WIDTH{1'b0}}, sq_dout};
  assign exact = dout_ext * dout_ext == rad_q;
  assign busy = state == ST_HOLD || occupancy != 2'd0;
  assign {out_root, out_exact} = head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      sq_radicand <= '0;
      rad_q <= '0;
    end else if (accept) begin
      state <= ST_HOLD;
      cnt <= CW'(HOLD_CYCLES - 1);
      sq_radicand <= in_radicand;
      rad_q <= in_radicand;
    end else if (state == ST_HOLD) begin
      state <= capture ? ST_IDLE : ST_HOLD;
      cnt <= cnt - CW'(!capture);
    end
  sq_result_fifo2 #(.DW(WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (capture),
    .wr_data   ({sq_dout, exact}),
    .occupancy (occupancy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );
endmodule

// File: tb/tb_square_extractor_seq_ctrl.sv
// tb_square_extractor_seq_ctrl: table, directed and randomized checks against an arithmetic sqrt model
module tb_square_extractor_seq_ctrl;
  import square_pkg::*;
  localparam int HOLD = 4;
  typedef struct {
    logic [7:0] rad;
    logic [3:0] root;
    logic       exact;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_radicand = 0, sq_radicand;
  logic [3:0] sq_dout, out_root;
  logic in_ready, out_valid, out_exact, busy;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  result_t sb_q[$], out_log[$];
  result_t sb_e, prev_res;
  int acc_cyc[$];
  bit hold_prev = 0;
  vec_t tbl[12];

  square_extractor_seq_ctrl #(.WIDTH(4), .HOLD_CYCLES(HOLD), .OBUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_radicand(in_radicand), .sq_radicand(sq_radicand), .sq_dout(sq_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
    .out_exact(out_exact), .busy(busy)
  );

  function automatic logic [3:0] ext_sqrt(input logic [7:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 4'(r);
  endfunction
  assign sq_dout = ext_sqrt(sq_radicand);

  function automatic result_t model(input int x);
    result_t m;
    int r;
    r = $rtoi($sqrt(real'(x)));
    m.root = 4'(r);
    m.exact = (r * r == x);
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) hold_prev = 0;
    else begin
      if (hold_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'({out_root, out_exact}), int'(prev_res));
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(int'(in_radicand)));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_log.push_back({out_root, out_exact});
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got root %0d with no pending radicand", out_root);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_root", int'(out_root), int'(sb_e.root));
          check("sb_exact", int'(out_exact), int'(sb_e.exact));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_res = {out_root, out_exact};
    end
  end

  task automatic send(input logic [7:0] v, input bit keep);
    bit ok = 0;
    in_radicand = v;
    in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep || !ok) in_valid = 0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: radicand %0d never accepted", v);
    end
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 1000 && out_log.size() < n; i++) @(posedge clk);
    #1;
    if (out_log.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_timeout: log has %0d entries, wanted %0d", out_log.size(), n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base, ab, lat, nex;
    bit done;
    tbl[0] = '{8'd0, 4'd0, 1'b1};    tbl[1] = '{8'd1, 4'd1, 1'b1};
    tbl[2] = '{8'd2, 4'd1, 1'b0};    tbl[3] = '{8'd3, 4'd1, 1'b0};
    tbl[4] = '{8'd4, 4'd2, 1'b1};    tbl[5] = '{8'd48, 4'd6, 1'b0};
    tbl[6] = '{8'd100, 4'd10, 1'b1}; tbl[7] = '{8'd143, 4'd11, 1'b0};
    tbl[8] = '{8'd144, 4'd12, 1'b1}; tbl[9] = '{8'd224, 4'd14, 1'b0};
    tbl[10] = '{8'd225, 4'd15, 1'b1}; tbl[11] = '{8'd255, 4'd15, 1'b0};
    #2;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_root", int'(out_root), 0);
    check("rst_out_exact", int'(out_exact), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sq_radicand", int'(sq_radicand), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    #1 check("idle_in_ready", int'(in_ready), 1);

    // 1: single 49, latency and one-cycle pulse
    base = out_log.size();
    send(8'd49, 0);
    check("t1_in_ready_hold", int'(in_ready), 0);
    check("t1_busy", int'(busy), 1);
    check("t1_sq_radicand", int'(sq_radicand), 49);
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
    end
    check("t1_latency", lat, HOLD + 1);
    check("t1_root", int'(out_root), 7);
    check("t1_exact", int'(out_exact), 1);
    @(negedge clk);
    check("t1_pulse", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // table of single transfers
    foreach (tbl[i]) begin
      base = out_log.size();
      send(tbl[i].rad, 0);
      wait_log(base + 1);
      if (out_log.size() > base) begin
        check($sformatf("tbl%0d_root", i), int'(out_log[base].root), int'(tbl[i].root));
        check($sformatf("tbl%0d_exact", i), int'(out_log[base].exact), int'(tbl[i].exact));
      end
    end

    // 2: back-to-back with in_valid held
    base = out_log.size();
    ab = acc_cyc.size();
    send(8'd50, 1);
    send(8'd255, 1);
    send(8'd0, 0);
    wait_log(base + 3);
    if (out_log.size() >= base + 3 && acc_cyc.size() >= ab + 3) begin
      check("t2_r0", int'({out_log[base].root, out_log[base].exact}), {4'd7, 1'b0});
      check("t2_r1", int'({out_log[base+1].root, out_log[base+1].exact}), {4'd15, 1'b0});
      check("t2_r2", int'({out_log[base+2].root, out_log[base+2].exact}), {4'd0, 1'b1});
      check("t2_gap0", acc_cyc[ab+1] - acc_cyc[ab], HOLD + 1);
      check("t2_gap1", acc_cyc[ab+2] - acc_cyc[ab+1], HOLD + 1);
    end

    // 3: backpressure fills the buffer and blocks admission
    out_ready = 0;
    base = out_log.size();
    send(8'd16, 0);
    send(8'd25, 0);
    in_radicand = 8'd36;
    in_valid = 1;
    ab = acc_cyc.size();
    repeat (12) @(posedge clk);
    #1;
    check("t3_no_accept", acc_cyc.size() - ab, 0);
    check("t3_in_ready", int'(in_ready), 0);
    check("t3_out_valid", int'(out_valid), 1);
    check("t3_head_root", int'(out_root), 4);
    out_ready = 1;
    send(8'd36, 0);
    wait_log(base + 3);
    if (out_log.size() >= base + 3) begin
      check("t3_r0", int'({out_log[base].root, out_log[base].exact}), {4'd4, 1'b1});
      check("t3_r1", int'({out_log[base+1].root, out_log[base+1].exact}), {4'd5, 1'b1});
      check("t3_r2", int'({out_log[base+2].root, out_log[base+2].exact}), {4'd6, 1'b1});
    end

    // 4: capture and pop on the same edge with one entry buffered
    out_ready = 0;
    base = out_log.size();
    send(8'd16, 0);
    repeat (HOLD + 2) @(posedge clk);
    #1 check("t4_one_buffered", int'(out_valid), 1);
    send(8'd81, 0);
    repeat (HOLD - 1) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("t4_log_one", out_log.size() - base, 1);
    check("t4_out_valid", int'(out_valid), 1);
    check("t4_head", int'({out_root, out_exact}), {4'd9, 1'b1});
    if (out_log.size() > base) check("t4_first", int'(out_log[base].root), 4);
    out_ready = 1;
    wait_log(base + 2);
    repeat (10) @(posedge clk);
    #1 check("t4_no_dup", out_log.size() - base, 2);
    check("t4_drained", int'(out_valid), 0);

    // 5: asynchronous reset in the middle of a hold
    base = out_log.size();
    send(8'd81, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("t5_in_ready", int'(in_ready), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_sq_radicand", int'(sq_radicand), 0);
    check("t5_out_root", int'(out_root), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    #1 check("t5_dropped", out_log.size() - base, 0);
    send(8'd64, 0);
    wait_log(base + 1);
    if (out_log.size() > base)
      check("t5_r64", int'({out_log[base].root, out_log[base].exact}), {4'd8, 1'b1});

    // 6: exhaustive sweep with random backpressure
    base = out_log.size();
    done = 0;
    fork
      begin
        for (int v = 0; v < 256; v++) begin
          send(8'(v), 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    wait_log(base + 256);
    check("t6_count", out_log.size() - base, 256);
    check("t6_sb_empty", sb_q.size(), 0);
    nex = 0;
    for (int i = base; i < out_log.size(); i++) nex += int'(out_log[i].exact);
    check("t6_exact_count", nex, 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
